// File: rtl/shift_serializer.sv
// shift_serializer: parallel-in serial-out transmitter with valid/last framing;
// back-to-back words stream with no idle gap.
module shift_serializer #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             hold,
    output logic             out,
    output logic             out_valid,
    output logic             last,
    output logic             busy
);
    localparam int CW   = $clog2(WIDTH);
    localparam int HEAD = MSB_FIRST ? WIDTH - 1 : 0;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] sreg, sreg_n, shifted;
    logic [CW-1:0]    cnt, cnt_n;
    logic             out_n, out_valid_n, last_n, accept;

    assign load_ready = reset && (state == IDLE || (last && !hold));
    assign accept     = load_valid && load_ready;
    assign busy       = state == SHIFT;
    // the register always presents the bit currently on out at position HEAD
    assign shifted    = MSB_FIRST ? sreg << 1 : sreg >> 1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            sreg      <= '0;
            cnt       <= '0;
            out       <= 1'b0;
            out_valid <= 1'b0;
            last      <= 1'b0;
        end else begin
            state     <= state_n;
            sreg      <= sreg_n;
            cnt       <= cnt_n;
            out       <= out_n;
            out_valid <= out_valid_n;
            last      <= last_n;
        end
    end

    always_comb begin
        state_n     = state;
        sreg_n      = sreg;
        cnt_n       = cnt;
        out_n       = out;
        out_valid_n = out_valid;
        last_n      = last;
        if (accept) begin
            state_n     = SHIFT;
            sreg_n      = load_data;
            cnt_n       = CW'(WIDTH - 1);
            out_n       = load_data[HEAD];
            out_valid_n = 1'b1;
            last_n      = 1'b0;
        end else if (state == SHIFT && !hold) begin
            if (cnt == '0) begin
                state_n     = IDLE;
                sreg_n      = '0;
                out_n       = 1'b0;
                out_valid_n = 1'b0;
                last_n      = 1'b0;
            end else begin
                sreg_n = shifted;
                cnt_n  = cnt - 1'b1;
                out_n  = shifted[HEAD];
                last_n = cnt == CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_shift_serializer.sv
// tb_shift_serializer: drives a WIDTH=4/MSB-first and a WIDTH=8/LSB-first instance
// with directed and random stimulus against a bit-queue reference model.
module tb_shift_serializer;
    logic       clk = 1'b0;
    logic       reset, load_valid, hold;
    logic [7:0] load_data;
    logic [1:0] rdy, o, ov, lst, bsy;
    int         checks = 0;
    int         errors = 0;
    bit         q[2][$];

    always #5 clk = ~clk;

    shift_serializer #(.WIDTH(4), .MSB_FIRST(1)) dut4 (
        .clk(clk), .reset(reset), .load_data(load_data[3:0]), .load_valid(load_valid),
        .load_ready(rdy[0]), .hold(hold), .out(o[0]), .out_valid(ov[0]), .last(lst[0]), .busy(bsy[0])
    );

    shift_serializer #(.WIDTH(8), .MSB_FIRST(0)) dut8 (
        .clk(clk), .reset(reset), .load_data(load_data), .load_valid(load_valid),
        .load_ready(rdy[1]), .hold(hold), .out(o[1]), .out_valid(ov[1]), .last(lst[1]), .busy(bsy[1])
    );

    task automatic check(input string tag, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", tag, $time, got, exp);
        end
    endtask

    function automatic bit exp_ready(int k);
        return reset && (q[k].size() == 0 || (q[k].size() == 1 && !hold));
    endfunction

    task automatic cycle(input logic r, input logic lv, input logic [7:0] d, input logic h);
        bit acc[2];
        @(negedge clk);
        reset = r; load_valid = lv; load_data = d; hold = h;
        #1;
        for (int k = 0; k < 2; k++) begin
            string w = k ? "w8" : "w4";
            check({"load_ready ", w}, rdy[k], exp_ready(k));
            check({"out_valid ", w}, ov[k], q[k].size() != 0);
            check({"out ", w}, o[k], q[k].size() != 0 ? q[k][0] : 1'b0);
            check({"last ", w}, lst[k], q[k].size() == 1);
            check({"busy ", w}, bsy[k], q[k].size() != 0);
            acc[k] = lv && exp_ready(k);
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            int w = k ? 8 : 4;
            if (!r) q[k].delete();
            else if (acc[k]) begin
                q[k].delete();
                for (int i = 0; i < w; i++) q[k].push_back(k == 0 ? d[w-1-i] : d[i]);
            end else if (q[k].size() != 0 && !h) q[k].delete(0);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1, 0, 8'h00, 0);
    endtask

    initial begin
        reset = 1'b0; load_valid = 1'b0; load_data = '0; hold = 1'b0;
        @(posedge clk);
        cycle(0, 1, 8'hFF, 0);
        cycle(0, 1, 8'hFF, 0);
        idle(2);
        cycle(1, 1, 8'hAB, 0);
        idle(9);
        cycle(1, 1, 8'h5B, 0);
        idle(3);
        cycle(1, 1, 8'h06, 0);
        idle(9);
        cycle(1, 1, 8'h3B, 0);
        idle(1);
        for (int i = 0; i < 3; i++) cycle(1, 1, 8'hC6, 1);
        idle(10);
        cycle(1, 1, 8'h9C, 0);
        idle(2);
        cycle(0, 1, 8'h77, 0);
        cycle(1, 1, 8'h55, 0);
        idle(9);
        cycle(1, 1, 8'hA5, 0);
        idle(9);
        for (int i = 0; i < 3000; i++)
            cycle($urandom_range(0, 49) != 0, $urandom_range(0, 9) < 6,
                  8'($urandom), $urandom_range(0, 3) == 0);
        idle(10);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
